cpu_if_queue: RTL and testbench

//  Next-generation IF stage. It owns the PC register and fetches one word per bus access

---
 rtl/cpu_if_queue_pkg.sv | 34 +++
 rtl/bus_if.sv | 13 +
 rtl/cpu_if_queue_inst_queue.sv | 71 +++++++
 rtl/cpu_if_queue.sv | 141 ++++++++++++++
 tb/tb_cpu_if_queue.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_if_queue_pkg.sv
// Shared types for the queued instruction-fetch stage.
package cpu_if_queue_pkg;

    typedef logic [31:0] Inst_t;
    typedef logic [31:0] InstAddr_t;

    localparam logic [31:0] IF_RESET_PC = 32'hbfc00000;

    typedef struct packed {
        logic iaddr_miss;
        logic iaddr_invalid;
        logic iaddr_illegal;
    } ExceptInfo_t;

    typedef struct packed {
        logic [31:0] phy_addr;
        logic        miss;
        logic        invalid;
        logic        illegal;
    } MMUResult_t;

    typedef struct packed {
        Inst_t       inst;
        InstAddr_t   pc;
        ExceptInfo_t except;
    } IFQEntry_t;

    typedef enum logic [1:0] {
        IF_IDLE,
        IF_WAIT,
        IF_DISCARD
    } IfState_t;

endpackage

// File: rtl/bus_if.sv
// Simple single-beat memory bus; the master holds a request until stall drops.
interface Bus_if;
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [3:0]  mask;
    logic [31:0] data_wr;
    logic [31:0] data_rd;
    logic        stall;

    modport master (output address, read, write, mask, data_wr, input data_rd, stall);
    modport slave  (input address, read, write, mask, data_wr, output data_rd, stall);
endinterface

// File: rtl/cpu_if_queue_inst_queue.sv
// Circular instruction buffer with one push port and ISSUE_WIDTH read/pop ports.
module inst_queue
    import cpu_if_queue_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int ISSUE_WIDTH = 2,
    localparam int PW  = $clog2(DEPTH),
    localparam int CW  = $clog2(DEPTH + 1),
    localparam int DNW = $clog2(ISSUE_WIDTH + 1)
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              flush,
    input  logic                              push,
    input  IFQEntry_t                         push_data,
    input  logic [DNW-1:0]                    deq_num,
    output logic [CW-1:0]                     count,
    output logic [ISSUE_WIDTH-1:0]            deq_valid,
    output IFQEntry_t [ISSUE_WIDTH-1:0]       deq_entry
);

    IFQEntry_t       mem_q [DEPTH];
    logic [PW-1:0]   head_q, head_d;
    logic [PW-1:0]   tail_q, tail_d;
    logic [CW-1:0]   count_q, count_d;
    logic [CW-1:0]   avail;

    // Pointer/count update; a flush discards both this cycle's push and pop.
    always_comb begin
        head_d  = head_q + PW'(deq_num);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + CW'(push) - CW'(deq_num);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; no reset needed since validity comes from count.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[tail_q] <= push_data;
    end

    // Read ports straight from storage: no push-to-pop bypass.
    for (genvar i = 0; i < ISSUE_WIDTH; i++) begin : g_rd
        logic [PW-1:0] rd_idx;
        assign rd_idx       = head_q + PW'(i);
        assign deq_entry[i] = mem_q[rd_idx];
        assign deq_valid[i] = CW'(i) < count_q;
    end

    assign count = count_q;
    assign avail = (count_q < CW'(ISSUE_WIDTH)) ? count_q : CW'(ISSUE_WIDTH);

    deq_num_legal: assert property (@(posedge clk) disable iff (rst) CW'(deq_num) <= avail);

endmodule

// File: rtl/cpu_if_queue.sv
// Queued IF stage: PC register, fetch FSM, MMU/bus glue feeding inst_queue.
module cpu_if_queue
    import cpu_if_queue_pkg::*;
#(
    parameter int          QUEUE_DEPTH = 8,
    parameter int          ISSUE_WIDTH = 2,
    parameter logic [31:0] RESET_PC    = IF_RESET_PC
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   fetch_en,
    input  logic                                   redirect,
    input  InstAddr_t                              redirect_pc,
    output InstAddr_t                              mmu_inst_vaddr,
    input  MMUResult_t                             mmu_inst_result,
    Bus_if.master                                  inst_bus,
    output logic [ISSUE_WIDTH-1:0]                 deq_valid,
    output IFQEntry_t [ISSUE_WIDTH-1:0]            deq_entry,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0]       deq_num,
    output logic                                   queue_full
);

    localparam int CW = $clog2(QUEUE_DEPTH + 1);

    IfState_t    state_q, state_d;
    InstAddr_t   pc_q, pc_d;
    logic        halted_q, halted_d;
    logic [31:0] req_paddr_q, req_paddr_d;
    InstAddr_t   req_pc_q, req_pc_d;

    logic        push, flush, issue, exc, bus_read;
    logic [31:0] bus_addr;
    IFQEntry_t   push_data;
    ExceptInfo_t exc_info;
    logic [CW-1:0] count;

    assign exc_info.iaddr_miss    = mmu_inst_result.miss;
    assign exc_info.iaddr_invalid = mmu_inst_result.invalid;
    assign exc_info.iaddr_illegal = mmu_inst_result.illegal || (pc_q[1:0] != 2'b00);
    assign exc   = |exc_info;
    // Room is judged on the start-of-cycle count; a same-cycle pop does not help.
    assign issue = (state_q == IF_IDLE) && fetch_en && !halted_q && !redirect
                   && (count < CW'(QUEUE_DEPTH));

    // Fetch FSM next state, PC update, bus drive and queue push.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        halted_d    = halted_q;
        req_paddr_d = req_paddr_q;
        req_pc_d    = req_pc_q;
        push        = 1'b0;
        push_data   = '0;
        flush       = 1'b0;
        bus_read    = 1'b0;
        bus_addr    = mmu_inst_result.phy_addr;
        case (state_q)
            IF_IDLE: begin
                if (issue && exc) begin
                    // Faulting fetch never reaches the bus; park until a redirect.
                    push      = 1'b1;
                    push_data = '{inst: '0, pc: pc_q, except: exc_info};
                    halted_d  = 1'b1;
                end else if (issue) begin
                    bus_read = 1'b1;
                    if (!inst_bus.stall) begin
                        push      = 1'b1;
                        push_data = '{inst: inst_bus.data_rd, pc: pc_q, except: '0};
                        pc_d      = pc_q + 32'd4;
                    end else begin
                        req_paddr_d = mmu_inst_result.phy_addr;
                        req_pc_d    = pc_q;
                        state_d     = IF_WAIT;
                    end
                end
            end
            IF_WAIT: begin
                bus_read = 1'b1;
                bus_addr = req_paddr_q;
                if (!inst_bus.stall) begin
                    push      = 1'b1;
                    push_data = '{inst: inst_bus.data_rd, pc: req_pc_q, except: '0};
                    pc_d      = req_pc_q + 32'd4;
                    state_d   = IF_IDLE;
                end
            end
            IF_DISCARD: begin
                // Bus access cannot be aborted; let it finish and drop the word.
                bus_read = 1'b1;
                bus_addr = req_paddr_q;
                if (!inst_bus.stall) state_d = IF_IDLE;
            end
            default: state_d = IF_IDLE;
        endcase
        if (redirect) begin
            flush    = 1'b1;
            push     = 1'b0;
            pc_d     = redirect_pc;
            halted_d = 1'b0;
            if (state_q == IF_WAIT) state_d = inst_bus.stall ? IF_DISCARD : IF_IDLE;
        end
    end

    // FSM and PC registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IF_IDLE;
            pc_q        <= RESET_PC;
            halted_q    <= 1'b0;
            req_paddr_q <= '0;
            req_pc_q    <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            halted_q    <= halted_d;
            req_paddr_q <= req_paddr_d;
            req_pc_q    <= req_pc_d;
        end
    end

    assign mmu_inst_vaddr   = pc_q;
    assign inst_bus.read    = bus_read;
    assign inst_bus.address = bus_addr;
    assign inst_bus.mask    = bus_read ? 4'b1111 : 4'b0000;
    assign inst_bus.write   = 1'b0;
    assign inst_bus.data_wr = '0;
    assign queue_full       = count == CW'(QUEUE_DEPTH);

    inst_queue #(.DEPTH(QUEUE_DEPTH), .ISSUE_WIDTH(ISSUE_WIDTH)) u_queue (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .push      (push),
        .push_data (push_data),
        .deq_num   (deq_num),
        .count     (count),
        .deq_valid (deq_valid),
        .deq_entry (deq_entry)
    );

endmodule

// File: tb/tb_cpu_if_queue.sv
// Directed bench for cpu_if_queue: vector table plus hand-written corner sequences.
module tb_cpu_if_queue;
    import cpu_if_queue_pkg::*;

    logic            clk = 1'b0;
    logic            rst;
    logic            fetch_en;
    logic            redirect;
    InstAddr_t       redirect_pc;
    InstAddr_t       mmu_inst_vaddr;
    MMUResult_t      mmu_res;
    logic [1:0]      deq_valid;
    IFQEntry_t [1:0] deq_entry;
    logic [1:0]      deq_num;
    logic            queue_full;
    logic            tb_stall;
    logic [31:0]     mmu_off;
    logic            mmu_miss;

    int n_vec = 0;
    int n_err = 0;

    Bus_if inst_bus ();

    // Identity MMU with an optional xor skew; memory returns address ^ 1.
    assign mmu_res = '{phy_addr: mmu_inst_vaddr ^ mmu_off, miss: mmu_miss, invalid: 1'b0, illegal: 1'b0};
    assign inst_bus.data_rd = inst_bus.address ^ 32'h1;
    assign inst_bus.stall   = tb_stall;

    always #5 clk = ~clk;

    cpu_if_queue dut (
        .clk             (clk),
        .rst             (rst),
        .fetch_en        (fetch_en),
        .redirect        (redirect),
        .redirect_pc     (redirect_pc),
        .mmu_inst_vaddr  (mmu_inst_vaddr),
        .mmu_inst_result (mmu_res),
        .inst_bus        (inst_bus),
        .deq_valid       (deq_valid),
        .deq_entry       (deq_entry),
        .deq_num         (deq_num),
        .queue_full      (queue_full)
    );

    typedef struct {
        logic        fe;
        logic [1:0]  dn;
        logic        exp_read;
        logic [31:0] exp_addr;
        logic [1:0]  exp_dv;
        logic [31:0] exp_pc0;
        logic        exp_full;
    } vec_t;

    vec_t tbl [16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Drive one cycle's inputs in the low phase, then settle for sampling.
    task automatic drive(input logic fe, input logic rd, input logic [31:0] rpc,
                         input logic st, input logic [1:0] dn,
                         input logic [31:0] off = 32'h0, input logic miss = 1'b0);
        @(negedge clk);
        fetch_en    = fe;
        redirect    = rd;
        redirect_pc = rpc;
        tb_stall    = st;
        deq_num     = dn;
        mmu_off     = off;
        mmu_miss    = miss;
        #1;
    endtask

    initial begin
        int pushes, pops, cyc, avail;
        logic [31:0] exp_pc;
        logic [1:0]  dn;
        bit want2;

        // Fill queue from reset, then drain down and test pop+push in one cycle.
        for (int k = 0; k < 10; k++)
            tbl[k] = '{fe: 1'b1, dn: 2'd0, exp_read: (k < 8), exp_addr: 32'hbfc00000 + 32'(4 * k),
                       exp_dv: (k == 0) ? 2'b00 : (k == 1) ? 2'b01 : 2'b11,
                       exp_pc0: 32'hbfc00000, exp_full: (k >= 8)};
        tbl[10] = '{1'b0, 2'd2, 1'b0, 32'h0,        2'b11, 32'hbfc00000, 1'b1};
        tbl[11] = '{1'b0, 2'd2, 1'b0, 32'h0,        2'b11, 32'hbfc00008, 1'b0};
        tbl[12] = '{1'b0, 2'd2, 1'b0, 32'h0,        2'b11, 32'hbfc00010, 1'b0};
        tbl[13] = '{1'b0, 2'd1, 1'b0, 32'h0,        2'b11, 32'hbfc00018, 1'b0};
        tbl[14] = '{1'b1, 2'd1, 1'b1, 32'hbfc00020, 2'b01, 32'hbfc0001c, 1'b0};
        tbl[15] = '{1'b0, 2'd0, 1'b0, 32'h0,        2'b01, 32'hbfc00020, 1'b0};

        rst = 1'b1; fetch_en = 1'b0; redirect = 1'b0; redirect_pc = '0;
        tb_stall = 1'b0; deq_num = '0; mmu_off = '0; mmu_miss = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_read", inst_bus.read, 1'b0);
        chk("rst_mask", inst_bus.mask, 4'h0);
        chk("rst_dv", deq_valid, 2'b00);
        chk("rst_full", queue_full, 1'b0);
        chk("rst_vaddr", mmu_inst_vaddr, 32'hbfc00000);
        chk("rst_write", inst_bus.write, 1'b0);
        chk("rst_data_wr", inst_bus.data_wr, 32'h0);

        for (int k = 0; k < 16; k++) begin
            drive(tbl[k].fe, 1'b0, 32'h0, 1'b0, tbl[k].dn);
            chk($sformatf("v%0d_read", k), inst_bus.read, tbl[k].exp_read);
            if (tbl[k].exp_read) begin
                chk($sformatf("v%0d_addr", k), inst_bus.address, tbl[k].exp_addr);
                chk($sformatf("v%0d_mask", k), inst_bus.mask, 4'hf);
            end
            chk($sformatf("v%0d_dv", k), deq_valid, tbl[k].exp_dv);
            if (tbl[k].exp_dv[0]) begin
                chk($sformatf("v%0d_pc0", k), deq_entry[0].pc, tbl[k].exp_pc0);
                chk($sformatf("v%0d_inst0", k), deq_entry[0].inst, tbl[k].exp_pc0 ^ 32'h1);
            end
            chk($sformatf("v%0d_full", k), queue_full, tbl[k].exp_full);
        end

        // Stall held 3 cycles on the 2nd access while the MMU mapping shifts.
        drive(1, 1, 32'h00400000, 0, 0);
        chk("s0_read", inst_bus.read, 1'b0);
        drive(1, 0, 0, 0, 0);
        chk("s1_addr", inst_bus.address, 32'h00400000);
        chk("s1_dv", deq_valid, 2'b00);
        drive(1, 0, 0, 1, 0);
        chk("s2_addr", inst_bus.address, 32'h00400004);
        drive(1, 0, 0, 1, 0, 32'h10000000);
        chk("s3_read", inst_bus.read, 1'b1);
        chk("s3_addr", inst_bus.address, 32'h00400004);
        chk("s3_mask", inst_bus.mask, 4'hf);
        drive(1, 0, 0, 1, 0, 32'h20000000);
        chk("s4_addr", inst_bus.address, 32'h00400004);
        drive(1, 0, 0, 0, 0, 32'h20000000);
        chk("s5_addr", inst_bus.address, 32'h00400004);
        drive(0, 0, 0, 0, 2);
        chk("s6_dv", deq_valid, 2'b11);
        chk("s6_pc0", deq_entry[0].pc, 32'h00400000);
        chk("s6_pc1", deq_entry[1].pc, 32'h00400004);
        chk("s6_inst1", deq_entry[1].inst, 32'h00400005);
        drive(0, 0, 0, 0, 0);
        chk("s7_dv", deq_valid, 2'b00);

        // Redirect while waiting: bus finishes, word dropped, fetch restarts.
        drive(1, 0, 0, 1, 0);
        chk("t0_addr", inst_bus.address, 32'h00400008);
        drive(1, 1, 32'h80001000, 1, 0);
        chk("t1_read", inst_bus.read, 1'b1);
        chk("t1_addr", inst_bus.address, 32'h00400008);
        drive(1, 0, 0, 1, 0);
        chk("t2_read", inst_bus.read, 1'b1);
        chk("t2_addr", inst_bus.address, 32'h00400008);
        chk("t2_dv", deq_valid, 2'b00);
        drive(1, 0, 0, 0, 0);
        chk("t3_read", inst_bus.read, 1'b1);
        chk("t3_addr", inst_bus.address, 32'h00400008);
        drive(1, 0, 0, 0, 0);
        chk("t4_dv", deq_valid, 2'b00);
        chk("t4_read", inst_bus.read, 1'b1);
        chk("t4_addr", inst_bus.address, 32'h80001000);
        drive(0, 0, 0, 0, 1);
        chk("t5_dv", deq_valid, 2'b01);
        chk("t5_pc0", deq_entry[0].pc, 32'h80001000);
        chk("t5_inst0", deq_entry[0].inst, 32'h80001001);

        // Misaligned redirect target: one exception entry, fetch halts.
        drive(1, 1, 32'h80000002, 0, 0);
        chk("u0_read", inst_bus.read, 1'b0);
        drive(1, 0, 0, 0, 0);
        chk("u1_read", inst_bus.read, 1'b0);
        drive(1, 0, 0, 0, 0);
        chk("u2_read", inst_bus.read, 1'b0);
        chk("u2_dv", deq_valid, 2'b01);
        chk("u2_pc0", deq_entry[0].pc, 32'h80000002);
        chk("u2_inst0", deq_entry[0].inst, 32'h0);
        chk("u2_illegal", deq_entry[0].except.iaddr_illegal, 1'b1);
        drive(1, 0, 0, 0, 0);
        chk("u3_read", inst_bus.read, 1'b0);
        chk("u3_dv", deq_valid, 2'b01);
        drive(1, 1, 32'h80000100, 0, 0);
        chk("u4_read", inst_bus.read, 1'b0);
        drive(1, 0, 0, 0, 0, 32'h0, 1'b1);
        chk("u5_read", inst_bus.read, 1'b0);
        drive(1, 0, 0, 0, 0);
        chk("u6_read", inst_bus.read, 1'b0);
        chk("u6_dv", deq_valid, 2'b01);
        chk("u6_pc0", deq_entry[0].pc, 32'h80000100);
        chk("u6_miss", deq_entry[0].except.iaddr_miss, 1'b1);
        chk("u6_illegal", deq_entry[0].except.iaddr_illegal, 1'b0);

        // Wrap: 20 pushes, fill to full, then pop alternating 1/2.
        drive(0, 1, 32'h00001000, 0, 0);
        pushes = 0; pops = 0; cyc = 0; want2 = 1'b0; exp_pc = 32'h00001000;
        while ((pushes < 20 || pops < 20) && cyc < 300) begin
            @(negedge clk);
            fetch_en = (pushes < 20);
            redirect = 1'b0;
            tb_stall = 1'b0;
            avail = deq_valid[1] ? 2 : deq_valid[0] ? 1 : 0;
            if (cyc < 12) dn = 2'd0;
            else begin
                dn = want2 ? 2'd2 : 2'd1;
                want2 = !want2;
                if (int'(dn) > avail) dn = 2'(avail);
            end
            deq_num = dn;
            #1;
            for (int i = 0; i < int'(dn); i++) begin
                chk($sformatf("w_pc%0d", pops), deq_entry[i].pc, exp_pc);
                chk($sformatf("w_inst%0d", pops), deq_entry[i].inst, exp_pc ^ 32'h1);
                exp_pc += 32'd4;
                pops++;
            end
            if (cyc == 10) begin
                chk("w_full", queue_full, 1'b1);
                chk("w_full_read", inst_bus.read, 1'b0);
            end
            if (inst_bus.read) pushes++;
            cyc++;
        end
        chk("w_timeout", 32'(cyc < 300), 32'd1);
        chk("w_pushes", 32'(pushes), 32'd20);
        chk("w_pops", 32'(pops), 32'd20);
        drive(0, 0, 0, 0, 0);
        chk("w_empty", deq_valid, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
